axis_matvec_stream_if: RTL and testbench

AXI-Stream front end for the matrix-vector / eigen datapath.
- Receives one frame as an N×N matrix (row-major, tlast on the final matrix beat) followed by an N-element vector (tlast on the final vector beat).
- N is selected per frame at run time, up to MAX_SIZE.
- Presents the matrix and vector to the compute core, captures the N-element result and streams it out with full AXI-Stream backpressure.
- Detects frame-length errors.

---
 rtl/axis_mv_pkg.sv | 21 ++
 rtl/axis_result_serializer.sv | 101 ++++++++++
 rtl/axis_matvec_stream_if.sv | 217 +++++++++++++++++++++
 tb/tb_axis_matvec_stream_if.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mv_pkg.sv
// Shared types and helpers for the matrix-vector AXI-Stream front end.
package axis_mv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_MATRIX,
        ST_RX_VECTOR,
        ST_DRAIN,
        ST_WAIT_RESULT,
        ST_TX_RESULT
    } state_t;

    // Effective frame dimension: out-of-range requests fall back to the maximum.
    function automatic int clamp_size(input int cfg, input int max_size);
        if ((cfg >= 1) && (cfg <= max_size)) begin
            return cfg;
        end
        return max_size;
    endfunction

endpackage

// File: rtl/axis_result_serializer.sv
// Captures the core's result vector and streams its first N entries out
// on an AXI-Stream master with full backpressure.
module axis_result_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_SIZE   = 32,
    parameter int SIZE_W     = $clog2(MAX_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_W-1:0]     size,
    input  logic [DATA_WIDTH-1:0] result_in [MAX_SIZE],
    input  logic                  result_valid,
    output logic                  result_ready,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  captured,
    output logic                  tx_last
);
    import axis_mv_pkg::*;

    localparam int IDX_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

    logic                  ready_q, ready_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic [SIZE_W-1:0]     idx_q, idx_d;
    logic [SIZE_W-1:0]     idx_nxt;
    logic [DATA_WIDTH-1:0] buf_q [MAX_SIZE];
    logic [DATA_WIDTH-1:0] buf_d [MAX_SIZE];
    int                    size_i;

    // Capture the result, then present one buffered entry per handshake; hold while stalled.
    always_comb begin
        ready_d  = ready_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        size_i   = int'(size);
        idx_nxt  = idx_q + SIZE_W'(1);
        captured = ready_q && result_valid;
        tx_last  = tvalid_q && m_tready && tlast_q;

        if (start) begin
            ready_d = 1'b1;
        end

        if (captured) begin
            ready_d = 1'b0;
            for (int i = 0; i < MAX_SIZE; i++) begin
                buf_d[i] = (i < size_i) ? result_in[i] : '0;
            end
            // First beat comes straight from the input so it is valid the cycle after capture.
            tvalid_d = 1'b1;
            tdata_d  = result_in[0];
            tlast_d  = (size == SIZE_W'(1));
            idx_d    = '0;
        end else if (tvalid_q && m_tready) begin
            if (tlast_q) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = '0;
                idx_d    = '0;
            end else begin
                idx_d   = idx_nxt;
                tdata_d = buf_q[idx_nxt[IDX_W-1:0]];
                tlast_d = (idx_nxt == (size - SIZE_W'(1)));
            end
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            idx_q    <= '0;
            buf_q    <= '{default: '0};
        end else begin
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
        end
    end

    assign result_ready = ready_q;
    assign m_tvalid     = tvalid_q;
    assign m_tdata      = tdata_q;
    assign m_tlast      = tlast_q;

endmodule

// File: rtl/axis_matvec_stream_if.sv
// AXI-Stream front end: receives an NxN matrix plus N-vector per frame,
// hands them to the compute core and streams the N-element result back out.
module axis_matvec_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_SIZE   = 32,
    parameter int SIZE_W     = $clog2(MAX_SIZE + 1)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [SIZE_W-1:0]     cfg_size,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] matrix_out [MAX_SIZE][MAX_SIZE],
    output logic [DATA_WIDTH-1:0] vector_out [MAX_SIZE],
    output logic [SIZE_W-1:0]     size_out,
    output logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] result_in [MAX_SIZE],
    input  logic                  result_valid,
    output logic                  result_ready,
    output logic                  err_len,
    output logic                  busy
);
    import axis_mv_pkg::*;

    localparam int IDX_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int K_W   = 2 * SIZE_W;

    state_t                state_q, state_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [SIZE_W-1:0]     row_q, row_d;
    logic [SIZE_W-1:0]     col_q, col_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [DATA_WIDTH-1:0] matrix_q [MAX_SIZE][MAX_SIZE];
    logic [DATA_WIDTH-1:0] matrix_d [MAX_SIZE][MAX_SIZE];
    logic [DATA_WIDTH-1:0] vector_q [MAX_SIZE];
    logic [DATA_WIDTH-1:0] vector_d [MAX_SIZE];
    logic                  data_valid_q, data_valid_d;
    logic                  err_len_q, err_len_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;

    logic                  hs;
    logic [SIZE_W-1:0]     neff;
    logic [K_W-1:0]        neff_w;
    logic [K_W-1:0]        target;
    logic [K_W-1:0]        k_inc;
    logic [SIZE_W-1:0]     row_b, col_b;
    logic                  phase_end;
    logic                  ser_start;
    logic                  ser_captured;
    logic                  ser_tx_last;

    // Receive FSM: frame parsing, array writes, length checking and result hand-off.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        row_d        = row_q;
        col_d        = col_q;
        k_d          = k_q;
        matrix_d     = matrix_q;
        vector_d     = vector_q;
        data_valid_d = 1'b0;
        err_len_d    = 1'b0;
        ser_start    = 1'b0;

        hs = s_axis_tvalid && tready_q;
        // In IDLE the incoming beat is matrix[0][0] of a new frame, so work from fresh counters.
        neff   = (state_q == ST_IDLE) ? SIZE_W'(clamp_size(int'(cfg_size), MAX_SIZE)) : size_q;
        neff_w = {{SIZE_W{1'b0}}, neff};
        row_b  = (state_q == ST_IDLE) ? '0 : row_q;
        col_b  = (state_q == ST_IDLE) ? '0 : col_q;
        k_inc  = ((state_q == ST_IDLE) ? '0 : k_q) + K_W'(1);
        target = (state_q == ST_RX_VECTOR) ? neff_w : (neff_w * neff_w);
        phase_end = (k_inc == target);

        case (state_q)
            ST_IDLE, ST_RX_MATRIX: begin
                if (hs) begin
                    if (state_q == ST_IDLE) begin
                        matrix_d = '{default: '0};
                        vector_d = '{default: '0};
                        size_d   = neff;
                    end
                    matrix_d[row_b[IDX_W-1:0]][col_b[IDX_W-1:0]] = s_axis_tdata;
                    if (col_b == (neff - SIZE_W'(1))) begin
                        col_d = '0;
                        row_d = row_b + SIZE_W'(1);
                    end else begin
                        col_d = col_b + SIZE_W'(1);
                        row_d = row_b;
                    end
                    k_d = k_inc;
                    if (phase_end && s_axis_tlast) begin
                        state_d = ST_RX_VECTOR;
                        row_d   = '0;
                        col_d   = '0;
                        k_d     = '0;
                    end else if (phase_end || s_axis_tlast) begin
                        err_len_d = 1'b1;
                        state_d   = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                        row_d     = '0;
                        col_d     = '0;
                        k_d       = '0;
                    end else begin
                        state_d = ST_RX_MATRIX;
                    end
                end
            end
            ST_RX_VECTOR: begin
                if (hs) begin
                    vector_d[col_q[IDX_W-1:0]] = s_axis_tdata;
                    col_d = col_q + SIZE_W'(1);
                    k_d   = k_inc;
                    if (phase_end && s_axis_tlast) begin
                        data_valid_d = 1'b1;
                        ser_start    = 1'b1;
                        state_d      = ST_WAIT_RESULT;
                        col_d        = '0;
                        k_d          = '0;
                    end else if (phase_end || s_axis_tlast) begin
                        err_len_d = 1'b1;
                        state_d   = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                        col_d     = '0;
                        k_d       = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RESULT: begin
                if (ser_captured) begin
                    state_d = ST_TX_RESULT;
                end
            end
            ST_TX_RESULT: begin
                if (ser_tx_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered status outputs track the state being entered.
        tready_d = (state_d == ST_IDLE) || (state_d == ST_RX_MATRIX) ||
                   (state_d == ST_RX_VECTOR) || (state_d == ST_DRAIN);
        busy_d   = (state_d != ST_IDLE);
    end

    // Receive-side registers and arrays.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            size_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            k_q          <= '0;
            matrix_q     <= '{default: '0};
            vector_q     <= '{default: '0};
            data_valid_q <= 1'b0;
            err_len_q    <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            row_q        <= row_d;
            col_q        <= col_d;
            k_q          <= k_d;
            matrix_q     <= matrix_d;
            vector_q     <= vector_d;
            data_valid_q <= data_valid_d;
            err_len_q    <= err_len_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
        end
    end

    axis_result_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_SIZE   (MAX_SIZE),
        .SIZE_W     (SIZE_W)
    ) u_ser (
        .clk          (aclk),
        .rst          (areset),
        .start        (ser_start),
        .size         (size_q),
        .result_in    (result_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .m_tvalid     (m_axis_tvalid),
        .m_tdata      (m_axis_tdata),
        .m_tlast      (m_axis_tlast),
        .m_tready     (m_axis_tready),
        .captured     (ser_captured),
        .tx_last      (ser_tx_last)
    );

    assign s_axis_tready = tready_q;
    assign matrix_out    = matrix_q;
    assign vector_out    = vector_q;
    assign size_out      = size_q;
    assign data_valid    = data_valid_q;
    assign err_len       = err_len_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_matvec_stream_if.sv
// Self-checking bench for axis_matvec_stream_if with MAX_SIZE=4.
module tb_axis_matvec_stream_if;

    localparam int DW = 32;
    localparam int MS = 4;
    localparam int SW = $clog2(MS + 1);

    logic          aclk;
    logic          areset;
    logic [SW-1:0] cfg_size;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [DW-1:0] matrix_out [MS][MS];
    logic [DW-1:0] vector_out [MS];
    logic [SW-1:0] size_out;
    logic          data_valid;
    logic [DW-1:0] result_in [MS];
    logic          result_valid;
    logic          result_ready;
    logic          err_len;
    logic          busy;

    axis_matvec_stream_if #(.DATA_WIDTH(DW), .MAX_SIZE(MS), .SIZE_W(SW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_size      (cfg_size),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .matrix_out    (matrix_out),
        .vector_out    (vector_out),
        .size_out      (size_out),
        .data_valid    (data_valid),
        .result_in     (result_in),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .err_len       (err_len),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int dv_cnt  = 0;
    int m_mode  = 0;
    int pat_cnt = 0;
    bit gap_en  = 0;
    logic [32:0] out_q [$];
    logic [DW-1:0] fb [32];

    typedef struct {
        logic [SW-1:0] cfg;
        int            nbeats;
        logic [31:0]   mask;
        int            exp_err;
        int            exp_dv;
        int            exp_size;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Output-ready generator: always ready, random, or the 1,0,0,1 pattern.
    always @(posedge aclk) begin
        #1;
        pat_cnt++;
        case (m_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
        endcase
    end

    // Monitor: pulse counters, output beat log and hold-while-stalled check.
    logic          stall_p = 1'b0;
    logic [DW-1:0] hold_d  = '0;
    logic          hold_l  = 1'b0;
    always @(negedge aclk) begin
        if (areset) begin
            stall_p = 1'b0;
        end else begin
            if (err_len)    err_cnt++;
            if (data_valid) dv_cnt++;
            if (stall_p) begin
                total++;
                if (!(m_tvalid && (m_tdata == hold_d) && (m_tlast == hold_l))) begin
                    bad++;
                    $display("FAIL tx_hold: got v=%0d d=%0d l=%0d expected v=1 d=%0d l=%0d",
                             m_tvalid, m_tdata, m_tlast, hold_d, hold_l);
                end
            end
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
            stall_p = m_tvalid && !m_tready;
            hold_d  = m_tdata;
            hold_l  = m_tlast;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Send one beat starting at a negedge; returns at the negedge after its handshake.
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int t = 0;
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            s_tvalid = 1'b0;
            @(negedge aclk);
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!s_tready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 200) chk("s_tready_timeout", 0, 1);
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] cfg, input int nb, input logic [31:0] mask);
        cfg_size = cfg;
        for (int b = 0; b < nb; b++) begin
            fb[b] = $urandom;
            send_beat(fb[b], mask[b]);
        end
    endtask

    // Expected arrays from the frame's beats: row-major matrix, then vector, zeros beyond N.
    task automatic check_arrays(input int n);
        int mism = 0;
        logic [DW-1:0] e;
        for (int r = 0; r < MS; r++) begin
            for (int c = 0; c < MS; c++) begin
                e = (r < n && c < n) ? fb[r * n + c] : '0;
                if (matrix_out[r][c] !== e) mism++;
            end
            e = (r < n) ? fb[n * n + r] : '0;
            if (vector_out[r] !== e) mism++;
        end
        chk("array_mismatches", mism, 0);
    endtask

    task automatic run_result(input int n, input int mode, input logic [DW-1:0] vals [MS]);
        int t = 0;
        int base;
        logic [32:0] e;
        base   = out_q.size();
        m_mode = mode;
        result_in = vals;
        while (!result_ready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("result_ready_seen", result_ready, 1);
        result_valid = 1'b1;
        @(negedge aclk);
        result_valid = 1'b0;
        chk("result_ready_drop", result_ready, 0);
        t = 0;
        while (out_q.size() < base + n && t < 400) begin
            @(negedge aclk);
            t++;
        end
        repeat (4) @(negedge aclk);
        chk("tx_count", out_q.size() - base, n);
        for (int i = 0; i < n && (base + i) < out_q.size(); i++) begin
            e = out_q[base + i];
            chk("tx_data", e[31:0], vals[i]);
            chk("tx_last", e[32], (i == n - 1) ? 1 : 0);
        end
        chk("busy_after_tx", busy, 0);
        m_mode = 0;
    endtask

    logic [DW-1:0] rv [MS];
    int eb, db, t;

    initial begin
        tbl[0]  = '{3'd2, 6,  32'h28,    0, 1, 2};
        tbl[1]  = '{3'd3, 5,  32'h10,    1, 0, 3};
        tbl[2]  = '{3'd3, 12, 32'h900,   0, 1, 3};
        tbl[3]  = '{3'd2, 6,  32'h20,    1, 0, 2};
        tbl[4]  = '{3'd0, 20, 32'h88000, 0, 1, 4};
        tbl[5]  = '{3'd5, 20, 32'h88000, 0, 1, 4};
        tbl[6]  = '{3'd1, 2,  32'h3,     0, 1, 1};
        tbl[7]  = '{3'd1, 3,  32'h5,     1, 0, 1};
        tbl[8]  = '{3'd4, 18, 32'h28000, 1, 0, 4};
        tbl[9]  = '{3'd1, 2,  32'h2,     1, 0, 1};
        tbl[10] = '{3'd7, 20, 32'h88000, 0, 1, 4};

        areset = 1'b1;
        cfg_size = '0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        result_valid = 1'b0;
        result_in = '{default: '0};
        repeat (3) @(negedge aclk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_size_out", size_out, 0);
        chk("rst_result_ready", result_ready, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("idle_s_tready", s_tready, 1);
        chk("idle_busy", busy, 0);

        // Nominal 2x2 frame with fixed data and fixed result.
        cfg_size = 3'd2;
        for (int b = 0; b < 6; b++) begin
            fb[b] = DW'(b + 1);
            send_beat(fb[b], (b == 3 || b == 5));
            if (b == 0) chk("nom_busy", busy, 1);
        end
        chk("nom_data_valid", data_valid, 1);
        chk("nom_s_tready_wait", s_tready, 0);
        chk("nom_m10", matrix_out[1][0], 3);
        chk("nom_v1", vector_out[1], 6);
        chk("nom_size", size_out, 2);
        @(negedge aclk);
        chk("nom_dv_pulse", data_valid, 0);
        check_arrays(2);
        rv = '{32'd9, 32'd8, 32'd0, 32'd0};
        run_result(2, 0, rv);

        // 4x4 frame with 1,0,0,1 output backpressure.
        send_frame(3'd4, 20, 32'h88000);
        for (int i = 0; i < MS; i++) rv[i] = $urandom;
        run_result(4, 2, rv);

        // Table of frames with random data and input gaps, random output backpressure.
        gap_en = 1;
        for (int v = 0; v < 11; v++) begin
            eb = err_cnt;
            db = dv_cnt;
            send_frame(tbl[v].cfg, tbl[v].nbeats, tbl[v].mask);
            repeat (3) @(negedge aclk);
            chk("tbl_err", err_cnt - eb, tbl[v].exp_err);
            chk("tbl_dv", dv_cnt - db, tbl[v].exp_dv);
            chk("tbl_size", size_out, tbl[v].exp_size);
            chk("tbl_busy", busy, tbl[v].exp_dv);
            if (tbl[v].exp_dv != 0) begin
                check_arrays(tbl[v].exp_size);
                for (int i = 0; i < MS; i++) rv[i] = $urandom;
                run_result(tbl[v].exp_size, 1, rv);
            end
        end
        gap_en = 0;

        // Asynchronous reset while the second of four result beats is on the bus.
        send_frame(3'd4, 20, 32'h88000);
        for (int i = 0; i < MS; i++) rv[i] = $urandom;
        result_in = rv;
        m_mode = 0;
        t = 0;
        while (!result_ready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        result_valid = 1'b1;
        @(negedge aclk);
        result_valid = 1'b0;
        t = 0;
        while (!m_tvalid && t < 50) begin
            @(negedge aclk);
            t++;
        end
        @(negedge aclk);
        chk("rst_mid_beat2", m_tdata, rv[1]);
        areset = 1'b1;
        #1;
        chk("rst_mid_tvalid", m_tvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tdata", m_tdata, 0);
        chk("rst_mid_size", size_out, 0);
        chk("rst_mid_m33", matrix_out[3][3], 0);
        chk("rst_mid_v0", vector_out[0], 0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        eb = err_cnt;
        db = dv_cnt;
        send_frame(3'd3, 12, 32'h900);
        repeat (3) @(negedge aclk);
        chk("post_rst_err", err_cnt - eb, 0);
        chk("post_rst_dv", dv_cnt - db, 1);
        check_arrays(3);
        for (int i = 0; i < MS; i++) rv[i] = $urandom;
        run_result(3, 1, rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
